// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: base opcode encodings,
// M-extension function codes, FSM state type and operand-signedness helpers.
package alu_mc_pkg;

  // Base ALU codes, carried on op[3:0] when op[4] = 0
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b1000;
  localparam logic [3:0] OP_SLL    = 4'b0001;
  localparam logic [3:0] OP_SLT    = 4'b0010;
  localparam logic [3:0] OP_SLTU   = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_SRL    = 4'b0101;
  localparam logic [3:0] OP_SRA    = 4'b1101;
  localparam logic [3:0] OP_OR     = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b0111;
  localparam logic [3:0] OP_PASS_B = 4'b1001;

  // M-extension function codes, carried on op[2:0] when op[4] = 1
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand a is treated as two's complement for these functions
  function automatic logic f_signed_a(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  // Operand b is treated as two's complement for these functions
  function automatic logic f_signed_b(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one accumulator pair. Works on magnitudes and fixes signs at the end.
// Built only when ALU_MC_MDU_EN is defined. A start pulse loads the operands;
// the following XLEN cycles each perform one iteration, and done/res are
// presented combinationally during the last iteration so the caller can
// register the final value on that same edge.
`ifdef ALU_MC_MDU_EN
module alu_mc_mdu_iter
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  logic              busy;
  logic [SHW-1:0]    cnt;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   mop;
  logic [2:0]        fn;
  logic              neg_q;
  logic              neg_r;
  logic              is_div;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [XLEN-1:0]   hi_nx;
  logic [XLEN-1:0]   lo_nx;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  assign is_div = fn[2];
  assign done   = busy && (cnt == SHW'(XLEN - 1));

  // Reduce signed operands to magnitudes before loading the iterator
  always_comb begin
    a_neg = f_signed_a(func) & a[XLEN-1];
    b_neg = f_signed_b(func) & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration: multiplier consumes lo LSB-first, divider consumes lo MSB-first
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mop} : '0);
    shifted = {hi, lo[XLEN-1]};
    ge      = (shifted >= {1'b0, mop});
    // when ge holds the true difference is below mop, so XLEN bits are exact
    diff    = shifted[XLEN-1:0] - mop;
    if (is_div) begin
      hi_nx = ge ? diff : shifted[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], ge};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the post-iteration value
  always_comb begin
    prod     = {hi_nx, lo_nx};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -lo_nx : lo_nx;
    r_fix    = neg_r ? -hi_nx : hi_nx;
    case (fn)
      F_MUL:                     res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             res = q_fix;
      default:                   res = r_fix;
    endcase
  end

  // Iteration control: busy flag and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + SHW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

  // Datapath: load on start, advance one step per busy cycle
  always_ff @(posedge clk) begin
    if (start) begin
      fn    <= func;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      hi    <= '0;
      if (func[2]) begin
        lo  <= a_mag;
        mop <= b_mag;
      end else begin
        lo  <= b_mag;
        mop <= a_mag;
      end
    end else if (busy) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU with IDLE/BUSY/DONE handshake FSM. Base operations and
// corner cases finish in one cycle; multiply/divide iterate for XLEN cycles.
// Optional feature macro: ALU_MC_MDU_EN builds the M-extension datapath;
// without it every op[4]=1 request returns result 0 with err set.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            err
);

  state_t          state;
  logic [XLEN-1:0] base_res;
  logic            base_err;
  logic [XLEN-1:0] imm_res;
  logic            imm_err;
  logic            go_busy;

  // Single-cycle base ALU; returns {err, result}
  function automatic logic [XLEN:0] base_alu(input logic [3:0]      code,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    logic                   e;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    r  = '0;
    e  = 1'b0;
    case (code)
      OP_ADD:    r = x + y;
      OP_SUB:    r = x - y;
      OP_SLL:    r = x << sh;
      OP_SLT:    r = {{(XLEN-1){1'b0}}, (xs < ys)};
      OP_SLTU:   r = {{(XLEN-1){1'b0}}, (x < y)};
      OP_XOR:    r = x ^ y;
      OP_SRL:    r = x >> sh;
      OP_SRA:    r = xs >>> sh;
      OP_OR:     r = x | y;
      OP_AND:    r = x & y;
      OP_PASS_B: r = y;
      default:   e = 1'b1;
    endcase
    return {e, r};
  endfunction

  assign in_ready = (state == ST_IDLE);

  // Base ALU evaluated on the live request operands
  always_comb begin
    {base_err, base_res} = base_alu(op[3:0], a, b);
  end

`ifdef ALU_MC_MDU_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;
  logic            b_zero;
  logic            sovf;

  // Choose single-cycle answer or hand off to the iterative unit
  always_comb begin
    b_zero  = (b == '0);
    sovf    = ((op[2:0] == F_DIV) || (op[2:0] == F_REM)) &&
              (a == MIN_NEG) && (b == '1);
    imm_res = base_res;
    imm_err = base_err;
    go_busy = 1'b0;
    if (op[4]) begin
      imm_err = 1'b0;
      if (op[2] && b_zero) begin
        imm_res = op[1] ? a : '1;
      end else if (sovf) begin
        imm_res = op[1] ? '0 : a;
      end else begin
        imm_res = '0;
        go_busy = 1'b1;
      end
    end
  end

  assign mdu_start = in_valid && in_ready && go_busy;

  alu_mc_mdu_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .func  (op[2:0]),
    .a     (a),
    .b     (b),
    .done  (mdu_done),
    .res   (mdu_res)
  );
`else
  // Without the M-extension every op[4]=1 request is unsupported
  always_comb begin
    imm_res = base_res;
    imm_err = base_err;
    go_busy = 1'b0;
    if (op[4]) begin
      imm_res = '0;
      imm_err = 1'b1;
    end
  end
`endif

  // Handshake FSM with registered result, err and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (go_busy) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= imm_res;
              err       <= imm_err;
            end
          end
        end
        ST_BUSY: begin
`ifdef ALU_MC_MDU_EN
          if (mdu_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= mdu_res;
            err       <= 1'b0;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32) with an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: expected result, err flag and cycles to out_valid
  function automatic void model(input logic [4:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r,
                                output logic e, output int lat);
    longint          sx;
    longint          sy;
    longint          t;
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned tu;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    r = 32'h0;
    e = 1'b0;
    lat = 1;
    if (!o[4]) begin
      case (o[3:0])
        4'b0000: r = x + y;
        4'b1000: r = x - y;
        4'b0001: r = x << y[4:0];
        4'b0010: r = (sx < sy) ? 32'd1 : 32'd0;
        4'b0011: r = (ux < uy) ? 32'd1 : 32'd0;
        4'b0100: r = x ^ y;
        4'b0101: r = x >> y[4:0];
        4'b1101: begin t = sx >>> y[4:0]; r = t[31:0]; end
        4'b0110: r = x | y;
        4'b0111: r = x & y;
        4'b1001: r = y;
        default: e = 1'b1;
      endcase
    end else begin
`ifdef ALU_MC_MDU_EN
      lat = 33;
      case (o[2:0])
        3'd0: begin tu = ux * uy; r = tu[31:0]; end
        3'd1: begin t = sx * sy; r = t[63:32]; end
        3'd2: begin t = sx * longint'(ux); r = t[63:32]; end
        3'd3: begin tu = ux * uy; r = tu[63:32]; end
        3'd4, 3'd6: begin
          if (y == 0) begin
            r = (o[2:0] == 3'd4) ? 32'hFFFF_FFFF : x;
            lat = 1;
          end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r = (o[2:0] == 3'd4) ? x : 32'h0;
            lat = 1;
          end else begin
            t = (o[2:0] == 3'd4) ? (sx / sy) : (sx % sy);
            r = t[31:0];
          end
        end
        default: begin
          if (y == 0) begin
            r = (o[2:0] == 3'd5) ? 32'hFFFF_FFFF : x;
            lat = 1;
          end else begin
            tu = (o[2:0] == 3'd5) ? (ux / uy) : (ux % uy);
            r = tu[31:0];
          end
        end
      endcase
`else
      e = 1'b1;
`endif
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request from IDLE, wait (bounded) for out_valid, then pop it
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic e, output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, err, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b err=%b res=%h, want 1 0 0 0",
               in_ready, out_valid, err, result);
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops [10] = '{5'b00000, 5'b01101, 5'b10001, 5'b10011, 5'b10100,
                              5'b10101, 5'b10110, 5'b11111, 5'b01010, 5'b01001};
    logic [31:0] as  [10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'h1234_5678,
                              32'h5, 32'h5};
    logic [31:0] bs  [10] = '{32'h1, 32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h2, 32'h9, 32'h6, 32'hCAFE_F00D};
    logic [31:0] r, er;
    logic        e, ee;
    int          lat, el;
    for (int i = 0; i < 10; i++) begin
      model(ops[i], as[i], bs[i], er, ee, el);
      run_op(ops[i], as[i], bs[i], r, e, lat);
      n_tests++;
      if (r !== er || e !== ee || lat !== el) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%b a=%h b=%h: got res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                 i, ops[i], as[i], bs[i], r, e, lat, er, ee, el);
      end
    end
  endtask

  task automatic test_random_base();
    logic [4:0]  o;
    logic [31:0] x, y, r, er;
    logic        e, ee;
    int          lat, el;
    for (int i = 0; i < 48; i++) begin
      o = {1'b0, 4'($urandom_range(0, 15))};
      x = pick_val();
      y = pick_val();
      model(o, x, y, er, ee, el);
      run_op(o, x, y, r, e, lat);
      n_tests++;
      if (r !== er || e !== ee || lat !== el) begin
        n_fail++;
        $display("FAIL base[%0d] op=%b a=%h b=%h: got res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                 i, o, x, y, r, e, lat, er, ee, el);
      end
    end
  endtask

  task automatic test_random_mext();
    logic [4:0]  o;
    logic [31:0] x, y, r, er;
    logic        e, ee;
    int          lat, el;
    for (int i = 0; i < 32; i++) begin
      o = {1'b1, 1'($urandom), 3'($urandom_range(0, 7))};
      x = pick_val();
      y = pick_val();
      if ($urandom_range(0, 7) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      model(o, x, y, er, ee, el);
      run_op(o, x, y, r, e, lat);
      n_tests++;
      if (r !== er || e !== ee || lat !== el) begin
        n_fail++;
        $display("FAIL mext[%0d] op=%b a=%h b=%h: got res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                 i, o, x, y, r, e, lat, er, ee, el);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] er;
    logic        ee;
    int          el;
    model(5'b00000, 32'h1111_2222, 32'h0000_3333, er, ee, el);
    op = 5'b00000; a = 32'h1111_2222; b = 32'h0000_3333; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 5'b01000; a = 32'h9; b = 32'h4;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || err !== ee) begin
        n_fail++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b res=%h err=%b, want 1 0 %h %b",
                 i, out_valid, in_ready, result, err, er, ee);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ignored_req: got vld=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic        ee;
    int          el;
    model(5'b00110, 32'hA5A5_0000, 32'h0000_5A5A, er, ee, el);
    op = 5'b00110; a = 32'hA5A5_0000; b = 32'h0000_5A5A;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== ((i % 2) == 0) || in_ready !== ((i % 2) == 1) ||
          (out_valid === 1'b1 && result !== er)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got vld=%b rdy=%b res=%h, want vld=%0d rdy=%0d res=%h",
                 i, out_valid, in_ready, result, (i % 2) == 0, (i % 2) == 1, er);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    bit seen;
    op = 5'b10101; a = 32'hDEAD_BEEF; b = 32'h0000_0013; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, err, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_busy: got rdy=%b vld=%b err=%b res=%h, want 1 0 0 0",
               in_ready, out_valid, err, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: got out_valid after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_base();
    test_random_mext();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
